exec_step_ctrl: RTL and testbench
=================================

# exec_step_ctrl

Execution sequencer for the 16-bit single-cycle datapath. It produces a registered one-cycle `step_en` that the program counter, register file and data memory use as their write/advance enable, replacing the raw debounced push-button clock. It supports single-step, free-run at a divided rate, a PC breakpoint, and halt-on-overflow, and it keeps a retired-instruction count for the VIO/display.

## Interface
- `RUN_DIV`, default 4: run-mode issue interval in `clk` cycles, must be ≥1. Boards override it, e.g. to 25_000_000.
- `PC_W`, default 9: program counter width.
- `clk` input 1: system clock; all state changes on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `step_req` input 1: debounced step button level; the block edge-detects it internally.
- `run_req` input 1: debounced run button level; edge-detected internally.
- `halt_req` input 1: level; stops run mode.
- `bp_en` input 1: breakpoint enable.
- `bp_addr` input PC_W: breakpoint PC.
- `ovf_halt_en` input 1: enables halt on ALU overflow.
- `pc` input PC_W: current PC from the program counter.
- `ovf_in` input 1: ALU overflow flag for the instruction at `pc`.
- `step_en` output 1: one-cycle datapath advance pulse, registered.
- `running` output 1: high while in RUN.
- `state` output 2: 00 HALTED, 01 STEP, 10 RUN, 11 BREAK.
- `halt_cause` output 2: 00 reset, 01 manual halt, 10 breakpoint, 11 overflow.
- `instr_count` output 16: number of retired instructions.

## Operation
- Edge detect: `step_rise = step_req & ~step_q`, and likewise `run_rise` for `run_req`. The previous-value flops reset to 0, so a button held high through reset produces one edge after reset.
- **HALTED**
  - `step_rise` → STEP.
  - `run_rise` (with no `step_rise`) → RUN. Clear `div_cnt` and set `skip_bp`.
  - If `step_rise` and `run_rise` arrive together, step wins.
- **STEP**
  - `step_en` = 1 for exactly this one cycle, with no breakpoint check.
  - Next state is HALTED.
  - If `ovf_in & ovf_halt_en` this cycle, set `halt_cause` = 11.
  - `halt_req` has no effect here; the step still completes.
- **RUN**
  - `div_cnt` counts 0..RUN_DIV-1 and wraps. The cycle with `div_cnt == RUN_DIV-1` is the issue cycle.
  - Evaluation order in the issue cycle is fixed:
    1. `halt_req` → HALTED with cause 01, no pulse.
    2. Breakpoint hit (`bp_en & pc == bp_addr & ~skip_bp`) → BREAK with cause 10, no pulse.
    3. Otherwise issue the pulse: `step_en` goes high the next cycle and `skip_bp` clears.
    4. If the pulse issued and `ovf_in & ovf_halt_en`, the instruction still retires, then → HALTED with cause 11.
  - `halt_req` in a non-issue cycle → HALTED with cause 01 immediately. `div_cnt` clears and no pulse follows.
  - `step_rise` and `run_rise` are ignored in RUN.
- **BREAK**
  - `step_en` = 0.
  - `step_rise` → STEP, which executes the breakpoint instruction.
  - `run_rise` → RUN with `skip_bp` set, so the first issue does not re-trap at the same PC.
  - `halt_req` → HALTED, cause unchanged.
- `instr_count` increments by 1 in every cycle where `step_en` = 1 and wraps from 0xFFFF to 0x0000. Only reset clears it.
- `halt_cause` updates only on the transitions listed above and holds otherwise.
- Width rules:
  - `div_cnt` is `$clog2(RUN_DIV)` bits, minimum 1.
  - With RUN_DIV = 1, every RUN cycle is an issue cycle, so `step_en` can stay high continuously.

## Timing
- Reset (asynchronous assert, synchronous-release design): `state` = HALTED, `step_en` = 0, `running` = 0, `instr_count` = 0, `halt_cause` = 00, `div_cnt` = 0, `skip_bp` = 0, edge flops = 0.
- Button edge to pulse:
  - `step_req` rising at clock N is detected at N+1, `state` = STEP at N+1, `step_en` high during N+1 to N+2.
  - `run_req` rising at N gives `state` = RUN at N+1. With RUN_DIV = 4, the first `step_en` is high during N+5.
- Breakpoint and overflow checks sample `pc` and `ovf_in` in the issue cycle. `pc` is stable there because it only changes on `step_en`.
- `step_en` never stays high for more than one cycle unless RUN_DIV = 1.
- After any exit from RUN, `step_en` is 0 from the following cycle onward, except for a pulse already registered in the issue cycle.
- `running` = (`state` == RUN), registered.

## Test plan
- Reset, then a step press (`step_req` 0→1 held for 10 cycles) → exactly one `step_en` pulse, `instr_count` = 1, `state` returns to 00; holding the button produces no further pulses.
- RUN_DIV = 4, run press, halt after 20 cycles → `step_en` every 4th cycle, 5 pulses, `instr_count` = 5, `halt_cause` = 01, `state` = 00.
- `bp_en` = 1, `bp_addr` = 0x003, with `pc` advanced by the bench on each `step_en`, run from `pc` = 0 → 3 pulses, then `state` = 11 with `pc` = 3 and `halt_cause` = 10. A second run press → first issue proceeds (`pc` goes to 4) and the block keeps running.
- `ovf_halt_en` = 1, `ovf_in` forced high at `pc` = 2 during run → the pulse at `pc` = 2 issues, `instr_count` = 3, `state` = 00, `halt_cause` = 11.
- `step_req` and `run_req` rising in the same cycle while HALTED → a single step only, `state` ends at 00. Reset asserted mid-run, between pulses → all outputs return to reset values immediately, with no `step_en` afterwards.
- `instr_count` preloaded via 65535 steps (RUN_DIV = 1), then one more step → `instr_count` wraps to 0x0000.

Source files
------------

// File: rtl/exec_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : exec_step_ctrl
// Description : Step/run sequencer producing the datapath advance pulse, with
//               PC breakpoint, halt-on-overflow and retired-instruction count.
// Revision    : 1.0
// ============================================================================
module exec_step_ctrl #(
  parameter int RUN_DIV = 4,
  parameter int PC_W    = 9
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            step_req,
  input  logic            run_req,
  input  logic            halt_req,
  input  logic            bp_en,
  input  logic [PC_W-1:0] bp_addr,
  input  logic            ovf_halt_en,
  input  logic [PC_W-1:0] pc,
  input  logic            ovf_in,
  output logic            step_en,
  output logic            running,
  output logic [1:0]      state,
  output logic [1:0]      halt_cause,
  output logic [15:0]     instr_count
);

  localparam int CNT_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(RUN_DIV - 1);

  localparam logic [1:0] CAUSE_MANUAL = 2'b01;
  localparam logic [1:0] CAUSE_BREAK  = 2'b10;
  localparam logic [1:0] CAUSE_OVF    = 2'b11;

  typedef enum logic [1:0] {
    S_HALTED = 2'b00,
    S_STEP   = 2'b01,
    S_RUN    = 2'b10,
    S_BREAK  = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic             step_en_q, step_en_d;
  logic             running_q;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic             skip_q, skip_d;
  logic             step_prev_q, run_prev_q;
  logic [15:0]      count_q;

  logic step_rise, run_rise, issue, bp_hit, ovf_hit;

  assign step_rise = step_req & ~step_prev_q;
  assign run_rise  = run_req & ~run_prev_q;
  assign issue     = (div_q == DIV_LAST);
  assign bp_hit    = bp_en & (pc == bp_addr) & ~skip_q;
  assign ovf_hit   = ovf_in & ovf_halt_en;

  always_comb begin
    state_d   = state_q;
    step_en_d = 1'b0;
    cause_d   = cause_q;
    div_d     = div_q;
    skip_d    = skip_q;
    case (state_q)
      S_HALTED: begin
        if (step_rise) begin
          state_d   = S_STEP;
          step_en_d = 1'b1;
        end else if (run_rise) begin
          state_d = S_RUN;
          div_d   = '0;
          skip_d  = 1'b1;
        end
      end
      S_STEP: begin
        state_d = S_HALTED;
        if (ovf_hit) cause_d = CAUSE_OVF;
      end
      S_RUN: begin
        // Halt wins over everything; a breakpoint suppresses the pulse.
        if (halt_req) begin
          state_d = S_HALTED;
          cause_d = CAUSE_MANUAL;
          div_d   = '0;
        end else if (issue) begin
          div_d = '0;
          if (bp_hit) begin
            state_d = S_BREAK;
            cause_d = CAUSE_BREAK;
          end else begin
            step_en_d = 1'b1;
            skip_d    = 1'b0;
            if (ovf_hit) begin
              state_d = S_HALTED;
              cause_d = CAUSE_OVF;
            end
          end
        end else begin
          div_d = div_q + CNT_W'(1);
        end
      end
      S_BREAK: begin
        if (step_rise) begin
          state_d   = S_STEP;
          step_en_d = 1'b1;
        end else if (run_rise) begin
          state_d = S_RUN;
          div_d   = '0;
          skip_d  = 1'b1;
        end else if (halt_req) begin
          state_d = S_HALTED;
        end
      end
      default: state_d = S_HALTED;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_HALTED;
      step_en_q   <= 1'b0;
      running_q   <= 1'b0;
      cause_q     <= 2'b00;
      div_q       <= '0;
      skip_q      <= 1'b0;
      step_prev_q <= 1'b0;
      run_prev_q  <= 1'b0;
      count_q     <= 16'h0000;
    end else begin
      state_q     <= state_d;
      step_en_q   <= step_en_d;
      running_q   <= (state_d == S_RUN);
      cause_q     <= cause_d;
      div_q       <= div_d;
      skip_q      <= skip_d;
      step_prev_q <= step_req;
      run_prev_q  <= run_req;
      count_q     <= count_q + 16'(step_en_q);
    end
  end

  assign step_en     = step_en_q;
  assign running     = running_q;
  assign state       = state_q;
  assign halt_cause  = cause_q;
  assign instr_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_exec_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_exec_step_ctrl
// Description : Two sequencers (RUN_DIV 4 and 1) on shared controls, each
//               compared every cycle against a cycle-level behavioural model.
// Revision    : 1.0
// ============================================================================
module tb_exec_step_ctrl;
  localparam int PC_W = 9;
  localparam int ST_HALT = 0, ST_STEP = 1, ST_RUN = 2, ST_BRK = 3;

  logic clk = 1'b0, reset_n = 1'b0;
  logic step_req = 1'b0, run_req = 1'b0, halt_req = 1'b0;
  logic bp_en = 1'b0, ovf_halt_en = 1'b0, ovf_force = 1'b0;
  logic [PC_W-1:0] bp_addr = '0, ovf_pc = '0;
  logic [PC_W-1:0] pc_a = '0, pc_b = '0;
  logic ovf_a, ovf_b;
  logic se_a, run_a, se_b, run_b;
  logic [1:0] st_a, hc_a, st_b, hc_b;
  logic [15:0] cnt_a, cnt_b;

  int checks = 0, failures = 0;

  int m_st[2], m_cnt[2], m_cause[2], m_ph[2];
  bit m_pulse[2], m_skip[2], m_sp[2], m_rp[2];

  assign ovf_a = ovf_force & (pc_a == ovf_pc);
  assign ovf_b = ovf_force & (pc_b == ovf_pc);

  exec_step_ctrl #(.RUN_DIV(4), .PC_W(PC_W)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .step_req(step_req), .run_req(run_req),
    .halt_req(halt_req), .bp_en(bp_en), .bp_addr(bp_addr),
    .ovf_halt_en(ovf_halt_en), .pc(pc_a), .ovf_in(ovf_a),
    .step_en(se_a), .running(run_a), .state(st_a), .halt_cause(hc_a),
    .instr_count(cnt_a));

  exec_step_ctrl #(.RUN_DIV(1), .PC_W(PC_W)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .step_req(step_req), .run_req(run_req),
    .halt_req(halt_req), .bp_en(bp_en), .bp_addr(bp_addr),
    .ovf_halt_en(ovf_halt_en), .pc(pc_b), .ovf_in(ovf_b),
    .step_en(se_b), .running(run_b), .state(st_b), .halt_cause(hc_b),
    .instr_count(cnt_b));

  always #5 clk = ~clk;

  // Program counter of each datapath advances once per step_en cycle.
  always @(negedge clk) begin
    if (!reset_n) begin
      pc_a = '0;
      pc_b = '0;
    end else begin
      if (se_a) pc_a = pc_a + 1'b1;
      if (se_b) pc_b = pc_b + 1'b1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset(input int i);
    m_st[i] = ST_HALT; m_cnt[i] = 0; m_cause[i] = 0; m_ph[i] = 0;
    m_pulse[i] = 0; m_skip[i] = 0; m_sp[i] = 0; m_rp[i] = 0;
  endtask

  // One clock of the sequencer rules; m_ph counts cycles spent in RUN.
  task automatic model_step(input int i, input int div, input logic [PC_W-1:0] p, input bit ov);
    bit sr, rr, nxt;
    sr  = step_req && !m_sp[i];
    rr  = run_req && !m_rp[i];
    nxt = 0;
    if (m_pulse[i]) m_cnt[i] = (m_cnt[i] + 1) % 65536;
    case (m_st[i])
      ST_HALT: begin
        if (sr) begin m_st[i] = ST_STEP; nxt = 1; end
        else if (rr) begin m_st[i] = ST_RUN; m_ph[i] = 0; m_skip[i] = 1; end
      end
      ST_STEP: begin
        m_st[i] = ST_HALT;
        if (ov && ovf_halt_en) m_cause[i] = 3;
      end
      ST_RUN: begin
        if (halt_req) begin
          m_st[i] = ST_HALT; m_cause[i] = 1;
        end else if (m_ph[i] % div == div - 1) begin
          if (bp_en && p == bp_addr && !m_skip[i]) begin
            m_st[i] = ST_BRK; m_cause[i] = 2;
          end else begin
            nxt = 1; m_skip[i] = 0;
            if (ov && ovf_halt_en) begin m_st[i] = ST_HALT; m_cause[i] = 3; end
          end
        end
        m_ph[i]++;
      end
      default: begin
        if (sr) begin m_st[i] = ST_STEP; nxt = 1; end
        else if (rr) begin m_st[i] = ST_RUN; m_ph[i] = 0; m_skip[i] = 1; end
        else if (halt_req) m_st[i] = ST_HALT;
      end
    endcase
    m_pulse[i] = nxt;
    m_sp[i] = step_req;
    m_rp[i] = run_req;
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      model_reset(0);
      model_reset(1);
    end else begin
      model_step(0, 4, pc_a, ovf_a);
      model_step(1, 1, pc_b, ovf_b);
    end
  end

  always @(negedge clk) begin
    chk("a_step_en", int'(se_a), int'(m_pulse[0]));
    chk("a_running", int'(run_a), int'(m_st[0] == ST_RUN));
    chk("a_state", int'(st_a), m_st[0]);
    chk("a_halt_cause", int'(hc_a), m_cause[0]);
    chk("a_instr_count", int'(cnt_a), m_cnt[0]);
    chk("b_step_en", int'(se_b), int'(m_pulse[1]));
    chk("b_running", int'(run_b), int'(m_st[1] == ST_RUN));
    chk("b_state", int'(st_b), m_st[1]);
    chk("b_halt_cause", int'(hc_b), m_cause[1]);
    chk("b_instr_count", int'(cnt_b), m_cnt[1]);
  end

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic count_pulses(input int n, output int pulses);
    pulses = 0;
    repeat (n) begin
      wait_cyc(1);
      if (se_a) pulses++;
    end
  endtask

  task automatic do_reset();
    wait_cyc(1);
    reset_n = 1'b0;
    step_req = 1'b0; run_req = 1'b0; halt_req = 1'b0;
    wait_cyc(3);
    reset_n = 1'b1;
    wait_cyc(1);
  endtask

  initial begin
    int np;
    do_reset();
    chk("reset_state", int'(st_a), 0);
    chk("reset_count", int'(cnt_a), 0);
    chk("reset_step_en", int'(se_a), 0);
    chk("reset_cause", int'(hc_a), 0);

    // Held step button yields exactly one pulse.
    step_req = 1'b1;
    count_pulses(10, np);
    chk("step_pulses", np, 1);
    chk("step_count", int'(cnt_a), 1);
    chk("step_state", int'(st_a), 0);
    step_req = 1'b0;
    wait_cyc(2);

    // Free run at RUN_DIV=4, manual halt in a non-issue cycle.
    do_reset();
    run_req = 1'b1;
    count_pulses(21, np);
    halt_req = 1'b1;
    wait_cyc(1);
    if (se_a) np++;
    halt_req = 1'b0;
    run_req = 1'b0;
    for (int k = 0; k < 6; k++) begin
      wait_cyc(1);
      if (se_a) np++;
    end
    chk("run_pulses", np, 5);
    chk("run_count", int'(cnt_a), 5);
    chk("run_cause", int'(hc_a), 1);
    chk("run_state", int'(st_a), 0);

    // Breakpoint at PC 3, then resume past it.
    do_reset();
    bp_en = 1'b1;
    bp_addr = 9'h003;
    run_req = 1'b1;
    wait_cyc(30);
    chk("bp_state", int'(st_a), 3);
    chk("bp_pc", int'(pc_a), 3);
    chk("bp_cause", int'(hc_a), 2);
    chk("bp_count", int'(cnt_a), 3);
    chk("model_bp_state", m_st[0], 3);
    run_req = 1'b0;
    wait_cyc(1);
    run_req = 1'b1;
    wait_cyc(10);
    chk("resume_state", int'(st_a), 2);
    chk("resume_pc", int'(pc_a), 5);
    halt_req = 1'b1;
    wait_cyc(2);
    halt_req = 1'b0;
    run_req = 1'b0;
    bp_en = 1'b0;

    // Overflow at PC 2 retires that instruction then halts.
    do_reset();
    ovf_halt_en = 1'b1;
    ovf_pc = 9'd2;
    ovf_force = 1'b1;
    run_req = 1'b1;
    wait_cyc(20);
    chk("ovf_count", int'(cnt_a), 3);
    chk("ovf_state", int'(st_a), 0);
    chk("ovf_cause", int'(hc_a), 3);
    chk("model_ovf_count", m_cnt[0], 3);
    run_req = 1'b0;
    ovf_force = 1'b0;
    ovf_halt_en = 1'b0;

    // Simultaneous step and run edges: step only.
    do_reset();
    step_req = 1'b1;
    run_req = 1'b1;
    count_pulses(6, np);
    chk("both_pulses", np, 1);
    chk("both_state", int'(st_a), 0);
    step_req = 1'b0;
    run_req = 1'b0;

    // Asynchronous reset between pulses during run.
    do_reset();
    run_req = 1'b1;
    wait_cyc(6);
    reset_n = 1'b0;
    #1;
    chk("midrst_state", int'(st_a), 0);
    chk("midrst_step_en", int'(se_a), 0);
    chk("midrst_running", int'(run_a), 0);
    chk("midrst_count", int'(cnt_a), 0);
    run_req = 1'b0;
    wait_cyc(2);
    reset_n = 1'b1;
    count_pulses(10, np);
    chk("midrst_no_pulse", np, 0);

    // Counter wrap on the RUN_DIV=1 instance.
    do_reset();
    run_req = 1'b1;
    wait_cyc(1);
    wait_cyc(65535);
    halt_req = 1'b1;
    wait_cyc(1);
    halt_req = 1'b0;
    run_req = 1'b0;
    wait_cyc(2);
    chk("wrap_preload", int'(cnt_b), 65535);
    chk("wrap_state", int'(st_b), 0);
    step_req = 1'b1;
    wait_cyc(4);
    step_req = 1'b0;
    chk("wrap_count", int'(cnt_b), 0);
    chk("model_wrap_count", m_cnt[1], 0);
    wait_cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
